mem_wb_pipe: RTL and testbench

MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

---
 rtl/mem_wb_pipe.sv | 98 +++++++++
 tb/tb_mem_wb_pipe.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register: formats sub-word loads, applies flush/stall priority
// and counts instructions retiring into write-back.
module mem_wb_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] address,
  input  logic [REG_AW-1:0] rd,
  input  logic              memtoreg,
  input  logic              regwrite,
  input  logic [2:0]        load_mode,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_regwrite,
  output logic              wb_valid,
  output logic [CNT_W-1:0]  retired_cnt
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              regwrite_q, regwrite_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_val;

  // Lane selection only meaningful for DATA_W == 32.
  always_comb begin
    byte_sel = read_data[7:0];
    case (address[1:0])
      2'b00:   byte_sel = read_data[7:0];
      2'b01:   byte_sel = read_data[15:8];
      2'b10:   byte_sel = read_data[23:16];
      default: byte_sel = read_data[31:24];
    endcase
    half_sel = address[1] ? read_data[31:16] : read_data[15:0];

    case (load_mode)
      3'b001:  load_val = {{(DATA_W-16){half_sel[15]}}, half_sel};
      3'b010:  load_val = {{(DATA_W-16){1'b0}}, half_sel};
      3'b011:  load_val = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      3'b100:  load_val = {{(DATA_W-8){1'b0}}, byte_sel};
      default: load_val = read_data;
    endcase
  end

  always_comb begin
    data_d     = data_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    if (flush) begin
      data_d     = '0;
      rd_d       = '0;
      regwrite_d = 1'b0;
      valid_d    = 1'b0;
    end else if (!stall) begin
      data_d     = memtoreg ? load_val : address;
      rd_d       = rd;
      regwrite_d = regwrite & in_valid & (rd != '0);
      valid_d    = in_valid;
      if (in_valid) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      data_q     <= data_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign wb_data     = data_q;
  assign wb_rd       = rd_q;
  assign wb_regwrite = regwrite_q;
  assign wb_valid    = valid_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: expected WB contents are queued when stimulus is
// driven and popped one cycle later; a CNT_W=4 instance checks counter wrap.
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, in_valid, memtoreg, regwrite;
  logic [31:0] read_data, address;
  logic [4:0]  rd;
  logic [2:0]  load_mode;

  logic [31:0] wb_data, wb_data4;
  logic [4:0]  wb_rd, wb_rd4;
  logic        wb_regwrite, wb_regwrite4, wb_valid, wb_valid4;
  logic [31:0] retired_cnt;
  logic [3:0]  retired_cnt4;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        v;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t model;
  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_wb_pipe dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .read_data(read_data), .address(address), .rd(rd), .memtoreg(memtoreg),
    .regwrite(regwrite), .load_mode(load_mode), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .wb_valid(wb_valid), .retired_cnt(retired_cnt)
  );

  mem_wb_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .read_data(read_data), .address(address), .rd(rd), .memtoreg(memtoreg),
    .regwrite(regwrite), .load_mode(load_mode), .wb_data(wb_data4), .wb_rd(wb_rd4),
    .wb_regwrite(wb_regwrite4), .wb_valid(wb_valid4), .retired_cnt(retired_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".data"}, wb_data, 32'h0);
    chk({tag, ".rd"}, {27'h0, wb_rd}, 32'h0);
    chk({tag, ".rw"}, {31'h0, wb_regwrite}, 32'h0);
    chk({tag, ".valid"}, {31'h0, wb_valid}, 32'h0);
    chk({tag, ".cnt"}, retired_cnt, 32'h0);
    chk({tag, ".cnt4"}, {28'h0, retired_cnt4}, 32'h0);
  endtask

  // One clock of stimulus; exp_data is the required wb_data if this edge captures.
  task automatic step(input string tag, input logic st, input logic fl, input logic iv,
                      input logic mtr, input logic rw, input logic [2:0] lm,
                      input logic [31:0] addr, input logic [31:0] rdata,
                      input logic [4:0] rdd, input logic [31:0] exp_data);
    exp_t e;
    @(negedge clk);
    stall = st; flush = fl; in_valid = iv; memtoreg = mtr; regwrite = rw;
    load_mode = lm; address = addr; read_data = rdata; rd = rdd;
    if (fl) begin
      model.data = '0; model.rd = '0; model.rw = 1'b0; model.v = 1'b0;
    end else if (!st) begin
      model.data = exp_data;
      model.rd   = rdd;
      model.rw   = rw && iv && (rdd != 5'd0);
      model.v    = iv;
      if (iv) begin
        model.cnt  = model.cnt + 32'd1;
        model.cnt4 = model.cnt4 + 4'd1;
      end
    end
    sb.push_back(model);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".data"}, wb_data, e.data);
    chk({tag, ".rd"}, {27'h0, wb_rd}, {27'h0, e.rd});
    chk({tag, ".rw"}, {31'h0, wb_regwrite}, {31'h0, e.rw});
    chk({tag, ".valid"}, {31'h0, wb_valid}, {31'h0, e.v});
    chk({tag, ".cnt"}, retired_cnt, e.cnt);
    chk({tag, ".cnt4"}, {28'h0, retired_cnt4}, {28'h0, e.cnt4});
  endtask

  initial begin
    model = '0;
    rst = 1'b1; stall = 0; flush = 0; in_valid = 0; memtoreg = 0; regwrite = 0;
    load_mode = 3'b000; address = 32'h0; read_data = 32'h0; rd = 5'd0;
    #1;
    chk_zero("reset_t0");
    @(posedge clk); #1;
    chk_zero("reset_edge");
    @(negedge clk);
    rst = 1'b0;

    // Load formatting
    step("lb_b3",   0, 0, 1, 1, 1, 3'b011, 32'h0000_1003, 32'h80FF_FF7F, 5'd3, 32'hFFFF_FF80);
    step("lbu_b3",  0, 0, 1, 1, 1, 3'b100, 32'h0000_1003, 32'h80FF_FF7F, 5'd3, 32'h0000_0080);
    step("lh_a2",   0, 0, 1, 1, 1, 3'b001, 32'h0000_2002, 32'h8001_1234, 5'd4, 32'hFFFF_8001);
    step("lh_a3",   0, 0, 1, 1, 1, 3'b001, 32'h0000_2003, 32'h8001_1234, 5'd4, 32'hFFFF_8001);
    step("lhu_a0",  0, 0, 1, 1, 1, 3'b010, 32'h0000_2000, 32'h1234_9ABC, 5'd5, 32'h0000_9ABC);
    step("lh_a0",   0, 0, 1, 1, 1, 3'b001, 32'h0000_2001, 32'h1234_9ABC, 5'd5, 32'hFFFF_9ABC);
    step("lb_b0",   0, 0, 1, 1, 1, 3'b011, 32'h0000_3000, 32'h1122_3344, 5'd6, 32'h0000_0044);
    step("lbu_b1",  0, 0, 1, 1, 1, 3'b100, 32'h0000_3001, 32'h1122_33F4, 5'd6, 32'h0000_0033);
    step("lb_b2",   0, 0, 1, 1, 1, 3'b011, 32'h0000_3002, 32'h00A5_0000, 5'd6, 32'hFFFF_FFA5);
    step("lw_a1",   0, 0, 1, 1, 1, 3'b000, 32'h0000_4001, 32'hDEAD_BEEF, 5'd8, 32'hDEAD_BEEF);
    step("lm111",   0, 0, 1, 1, 1, 3'b111, 32'h0000_4003, 32'hCAFE_BABE, 5'd8, 32'hCAFE_BABE);
    // ALU result path and rd==0 write suppression
    step("alu",     0, 0, 1, 0, 1, 3'b011, 32'h1234_5678, 32'hFFFF_FFFF, 5'd7, 32'h1234_5678);
    step("alu_rd0", 0, 0, 1, 0, 1, 3'b000, 32'h1234_5678, 32'h0,         5'd0, 32'h1234_5678);
    step("inv_rd",  0, 0, 0, 0, 1, 3'b000, 32'h0000_0055, 32'h0,         5'd9, 32'h0000_0055);

    // Stall holds A for three cycles despite changing inputs, then flush wins over stall
    step("cap_A",   0, 0, 1, 0, 1, 3'b000, 32'hAAAA_0000, 32'h0,         5'd9, 32'hAAAA_0000);
    for (int i = 0; i < 3; i++)
      step("stall", 1, 0, 1, 1, 1, 3'(i), 32'h0BAD_0000 + 32'(i), 32'h5555_5555, 5'd31, 32'h0);
    step("flush_st", 1, 1, 1, 1, 1, 3'b000, 32'h1111_1111, 32'h2222_2222, 5'd12, 32'h0);
    step("post_fl",  0, 0, 1, 0, 0, 3'b000, 32'h0000_0777, 32'h0,        5'd13, 32'h0000_0777);

    // Asynchronous reset between edges, while a stall is in progress
    @(negedge clk);
    stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(posedge clk); #1;
    chk_zero("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    model = '0;
    step("after_rst", 0, 0, 1, 0, 1, 3'b000, 32'h0000_ABCD, 32'h0,       5'd2, 32'h0000_ABCD);

    // Narrow counter wraps: 17 valid captures from reset leave it at 1
    for (int i = 0; i < 16; i++)
      step("wrap", 0, 0, 1, 0, 1, 3'b000, 32'(i), 32'h0, 5'd1, 32'(i));
    chk("cnt4_17", {28'h0, retired_cnt4}, 32'h1);
    step("inv_cap", 0, 0, 0, 0, 1, 3'b000, 32'h0000_0099, 32'h0, 5'd3, 32'h0000_0099);
    chk("cnt4_hold", {28'h0, retired_cnt4}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
